// File: rtl/hs_rx_fifo_if.sv
// hs_rx_fifo_if: master-to-endpoint word handshake.
//   valid    master -> slave  word held on data
//   data     master -> slave  DW-bit write word
//   ready    slave  -> master endpoint can take a word this cycle
//   response slave  -> master one-cycle acknowledge of an accepted word
interface hs_rx_fifo_if #(parameter int DW = 32);
  logic          valid;
  logic [DW-1:0] data;
  logic          ready;
  logic          response;

  modport master (output valid, data, input  ready, response);
  modport slave  (input  valid, data, output ready, response);
endinterface

// File: rtl/hs_rx_fifo.sv
// hs_rx_fifo: slave-side receive endpoint with a first-word-fall-through FIFO.
// Each accepted word is acknowledged with a one-cycle response pulse and
// queued; the consumer drains the head through out_valid/out_ready.
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   bus (slave)       valid/data in, ready/response out (both registered)
//   out_valid/out_data/out_ready  FWFT consumer side
//   count             occupancy 0..DEPTH
// Optional feature macro HS_PARITY_EN: adds data_par (even parity over data)
// and sticky par_err; a bad-parity word is still acknowledged but dropped.
module hs_rx_fifo #(
  parameter int DW = 32,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset,
  hs_rx_fifo_if.slave   bus,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [AW:0]   count
`ifdef HS_PARITY_EN
  ,
  input  logic          data_par,
  output logic          par_err
`endif
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C1   = (AW+1)'(1);
  localparam logic [AW-1:0] P1   = AW'(1);

  typedef enum logic [1:0] {IDLE, ACK, DROP} state_t;

  state_t        state, state_n;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt_n;
  logic          ready_q, resp_q, ready_n, resp_n;
  logic          accept, word_ok, push, pop;

  assign bus.ready    = ready_q;
  assign bus.response = resp_q;
  assign accept       = bus.valid & ready_q;

`ifdef HS_PARITY_EN
  // Even parity: the word plus its parity bit carries an even number of ones.
  assign word_ok = ~(^{bus.data, data_par});
`else
  assign word_ok = 1'b1;
`endif

  assign push      = accept & word_ok;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign out_data  = mem[rd_ptr];

  always_comb begin
    cnt_n = count;
    case ({push, pop})
      2'b10:   cnt_n = count + C1;
      2'b01:   cnt_n = count - C1;
      default: cnt_n = count;
    endcase
  end

  // ready/response are registered decodes of the next state, so ready drops
  // on the very edge that accepts a word or fills the FIFO.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = ACK;
      ACK:     state_n = bus.valid ? DROP : IDLE;
      DROP:    if (!bus.valid) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    ready_n = (state_n == IDLE) && (cnt_n != FULL);
    resp_n  = (state_n == ACK);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      resp_q  <= 1'b0;
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      state   <= state_n;
      ready_q <= ready_n;
      resp_q  <= resp_n;
      count   <= cnt_n;
      if (push) wr_ptr <= wr_ptr + P1;
      if (pop)  rd_ptr <= rd_ptr + P1;
    end
  end

`ifdef HS_PARITY_EN
  always_ff @(posedge clk) begin
    if (!reset)                  par_err <= 1'b0;
    else if (accept && !word_ok) par_err <= 1'b1;
  end
`endif

  // Storage is deliberately not cleared on reset.
  always_ff @(posedge clk) begin
    if (reset && push) mem[wr_ptr] <= bus.data;
  end
endmodule

// File: tb/tb_hs_rx_fifo.sv
// tb_hs_rx_fifo: directed scenarios plus randomized traffic, all checked
// every cycle against a queue-based reference of the endpoint's rules.
module tb_hs_rx_fifo;
  localparam int DW = 32, AW = 2, DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hs_rx_fifo_if #(.DW(DW)) bus ();
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic [AW:0]   count;
`ifdef HS_PARITY_EN
  logic data_par, par_err;
`endif

  hs_rx_fifo #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count)
`ifdef HS_PARITY_EN
    , .data_par(data_par), .par_err(par_err)
`endif
  );

  // Reference: queue of stored words plus the expected handshake outputs.
  logic [DW-1:0] q[$];
  bit m_rdy, m_resp, m_hold, m_perr;
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, check on negedge.
  task automatic step(input logic r, input logic v, input logic [DW-1:0] d,
                      input logic p, input logic ordy);
    bit acc, ok;
    reset = r; bus.valid = v; bus.data = d; out_ready = ordy;
`ifdef HS_PARITY_EN
    data_par = p;
    ok = ((^d) == p);
`else
    ok = 1'b1;
`endif
    @(posedge clk);
    if (!r) begin
      q.delete(); m_rdy = 0; m_resp = 0; m_hold = 0; m_perr = 0;
    end else begin
      acc = v && m_rdy;
      if (q.size() != 0 && ordy) void'(q.pop_front());
      if (acc && ok) q.push_back(d);
      if (acc && !ok) m_perr = 1;
      m_resp = acc;
      // A held valid must be released (or seen low after the ack) before
      // the next word can be taken; a full FIFO also blocks.
      m_rdy  = !acc && (!m_hold || !v) && (q.size() < DEPTH);
      m_hold = acc || (m_hold && v);
    end
    @(negedge clk);
    chk("ready", bus.ready, m_rdy);
    chk("response", bus.response, m_resp);
    chk("out_valid", out_valid, q.size() != 0);
    chk("count", count, q.size());
    if (q.size() != 0) chk("out_data", out_data, q[0]);
`ifdef HS_PARITY_EN
    chk("par_err", par_err, m_perr);
`endif
  endtask

  task automatic push(input logic [DW-1:0] w);
    int n = 0;
    while (!m_rdy && n < 20) begin step(1, 1, w, ^w, 0); n++; end
    chk("push_wait", n < 20, 1);
    step(1, 1, w, ^w, 0);
    step(1, 0, '0, 1'b0, 0);
  endtask

  initial begin
    logic [DW-1:0] d;
    logic v, o, p;

    // 1: reset held two cycles
    step(0, 0, '0, 0, 0);
    step(0, 0, '0, 0, 0);
    chk("t1_ready_rst", bus.ready, 0);
    step(1, 0, '0, 0, 0);
    chk("t1_ready", bus.ready, 1);
    chk("t1_count", count, 0);

    // 2: single word, response exactly one cycle
    step(1, 1, 32'hA5A5_0001, ^32'hA5A5_0001, 0);
    chk("t2_resp", bus.response, 1);
    step(1, 0, '0, 0, 0);
    chk("t2_resp_off", bus.response, 0);
    chk("t2_count", count, 1);
    chk("t2_data", out_data, 32'hA5A5_0001);
    step(1, 0, '0, 0, 1);

    // 3: valid held for 5 cycles after the ack
    step(1, 1, 32'h3333, ^32'h3333, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 32'h3333, ^32'h3333, 0);
      chk("t3_ready", bus.ready, 0);
    end
    chk("t3_count", count, 1);
    step(1, 0, '0, 0, 0);
    chk("t3_release", bus.ready, 1);
    step(1, 0, '0, 0, 1);

    // 4: fill then drain in order across the pointer wrap
    for (int i = 1; i <= 4; i++) push(DW'(i));
    chk("t4_count", count, 4);
    chk("t4_ready", bus.ready, 0);
    for (int i = 1; i <= 4; i++) begin
      chk("t4_head", out_data, i);
      step(1, 0, '0, 0, 1);
    end
    chk("t4_empty", count, 0);

    // 5: full, master waiting, pop frees a slot, then push+pop together
    for (int i = 1; i <= 4; i++) push(DW'(i));
    step(1, 1, 32'd5, ^32'd5, 1);
    chk("t5_ready", bus.ready, 1);
    step(1, 1, 32'd5, ^32'd5, 1);
    chk("t5_count", count, 3);
    step(1, 0, '0, 0, 0);
    for (int i = 3; i <= 5; i++) begin
      chk("t5_head", out_data, i);
      step(1, 0, '0, 0, 1);
    end

`ifdef HS_PARITY_EN
    // 6: bad parity is acknowledged but dropped, error is sticky
    step(0, 0, '0, 0, 0);
    step(1, 0, '0, 0, 0);
    step(1, 1, 32'h1, 1'b0, 0);
    chk("t6_resp", bus.response, 1);
    step(1, 0, '0, 0, 0);
    chk("t6_count", count, 0);
    for (int i = 0; i < 3; i++) step(1, 0, '0, 0, 1);
    chk("t6_perr", par_err, 1);
`endif

    // Randomized traffic with one reset in the middle
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      o = ($urandom_range(0, 2) == 0);
      d = $urandom;
      p = ^d;
`ifdef HS_PARITY_EN
      if ($urandom_range(0, 9) == 0) p = ~p;
`endif
      step((i != 200), v, d, p, o);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
